// File: rtl/trans_pkg.sv
// Shared definitions for the counter readout sequencer: sequencer states,
// counter channel numbering and default widths.
package trans_pkg;

  localparam int DEF_COUNT_W = 6;
  localparam int DEF_IDX_W   = 3;
  localparam int DEF_NUM_CH  = 5;
  localparam int DEF_TIMEOUT = 15;

  // Channel numbering as seen by the packet counter.
  localparam int CH_EGR0 = 0;
  localparam int CH_EGR1 = 1;
  localparam int CH_EGR2 = 2;
  localparam int CH_EGR3 = 3;
  localparam int CH_ING  = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT      = 3'd3,
    S_SUM       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Bits needed to hold a count of 0..t.
  function automatic int timer_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/cont_reader_if.sv
// Query/return bus between the readout sequencer and the counter block.
interface cont_reader_if #(
  parameter int COUNT_W = trans_pkg::DEF_COUNT_W,
  parameter int IDX_W   = trans_pkg::DEF_IDX_W
) ();

  logic               req;           // one-cycle read request
  logic [IDX_W-1:0]   idx;           // channel being queried
  logic [COUNT_W-1:0] data_in_cont;  // returned counter value
  logic               valid_cont;    // qualifies data_in_cont
  logic               idle;          // counter block FSM is idle

  // Sequencer side.
  modport master (
    output req,
    output idx,
    input  data_in_cont,
    input  valid_cont,
    input  idle
  );

  // Counter block side.
  modport slave (
    input  req,
    input  idx,
    output data_in_cont,
    output valid_cont,
    output idle
  );

endinterface

// File: rtl/wait_timer.sv
// Response-wait timer: reloaded on clear, counts down while enabled and
// flags expired on the last cycle that is still allowed to answer.
module wait_timer import trans_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT);
  // Loading TIMEOUT-1 makes the TIMEOUT-th enabled cycle read as zero.
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // Reload on clear; otherwise step down once per enabled cycle, holding at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= LOAD;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expired = en && (count_reg == '0);

endmodule

// File: rtl/cont_reader.sv
// Readout sequencer for the packet counter: waits for the counter block to
// go idle, queries each channel in turn, captures the returns and publishes
// the egress total with an egress/ingress balance check.
module cont_reader import trans_pkg::*; #(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  cont_reader_if.master             bus,
  output logic [NUM_CH*COUNT_W-1:0] counts,
  output logic [COUNT_W+1:0]        egress_total,
  output logic                      balanced,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      stale
);

  localparam int SUM_W = COUNT_W + 2;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  state_t                    state_reg;
  logic [IDX_W-1:0]          k_reg;
  logic                      req_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [NUM_CH*COUNT_W-1:0] counts_reg;
  logic [SUM_W-1:0]          egress_total_reg;
  logic                      balanced_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic                      timeout_err_reg;
  logic                      stale_reg;

  logic                      timer_clear;
  logic                      timer_en;
  logic                      timer_expired;

  logic [COUNT_W-1:0]        slot [NUM_CH];
  logic [SUM_W-1:0]          egress_sum_next;
  logic                      balanced_next;
  logic                      past_wait_idle;

  // Per-channel view of the packed capture register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign slot[gi] = counts_reg[gi*COUNT_W +: COUNT_W];
    end
  endgenerate

  // Egress total and balance, computed from the captured slots.
  always_comb begin
    egress_sum_next = SUM_W'(slot[CH_EGR0]) + SUM_W'(slot[CH_EGR1])
                    + SUM_W'(slot[CH_EGR2]) + SUM_W'(slot[CH_EGR3]);
    balanced_next   = (egress_sum_next == SUM_W'(slot[CH_ING]));
  end

  // Timer is rearmed by the request cycle and runs only while awaiting data.
  assign timer_clear = (state_reg == S_REQ);
  assign timer_en    = (state_reg == S_WAIT);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Once the idle gate has been passed, any idle drop marks the snapshot stale.
  assign past_wait_idle = (state_reg == S_REQ) || (state_reg == S_WAIT) ||
                          (state_reg == S_SUM) || (state_reg == S_DONE);

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      k_reg            <= '0;
      req_reg          <= 1'b0;
      idx_reg          <= '0;
      counts_reg       <= '0;
      egress_total_reg <= '0;
      balanced_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      timeout_err_reg  <= 1'b0;
      stale_reg        <= 1'b0;
    end else begin
      req_reg  <= 1'b0;
      done_reg <= 1'b0;

      if (past_wait_idle && !bus.idle) begin
        stale_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg       <= S_WAIT_IDLE;
            busy_reg        <= 1'b1;
            timeout_err_reg <= 1'b0;
            stale_reg       <= 1'b0;
            k_reg           <= '0;
          end
        end

        S_WAIT_IDLE: begin
          if (bus.idle) begin
            state_reg <= S_REQ;
            req_reg   <= 1'b1;
            idx_reg   <= k_reg;
          end
        end

        S_REQ: begin
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.valid_cont) begin
            counts_reg[k_reg*COUNT_W +: COUNT_W] <= bus.data_in_cont;
            if (k_reg == LAST_CH) begin
              state_reg <= S_SUM;
            end else begin
              k_reg     <= k_reg + IDX_W'(1);
              idx_reg   <= k_reg + IDX_W'(1);
              req_reg   <= 1'b1;
              state_reg <= S_REQ;
            end
          end else if (timer_expired) begin
            // Unread slots keep their previous values.
            timeout_err_reg <= 1'b1;
            state_reg       <= S_DONE;
          end
        end

        S_SUM: begin
          egress_total_reg <= egress_sum_next;
          balanced_reg     <= balanced_next;
          state_reg        <= S_DONE;
        end

        S_DONE: begin
          // done is registered out of this state, so it shows as busy drops.
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req      = req_reg;
  assign bus.idx      = idx_reg;
  assign counts       = counts_reg;
  assign egress_total = egress_total_reg;
  assign balanced     = balanced_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign timeout_err  = timeout_err_reg;
  assign stale        = stale_reg;

endmodule

// File: tb/tb_cont_reader.sv
// Bench for cont_reader: a responder answers each query after a configured
// latency, a sequence-level model predicts request cycles, done cycle and
// published results, and a per-cycle checker compares the DUT against it.
module tb_cont_reader;
  import trans_pkg::*;

  localparam int COUNT_W = 6;
  localparam int IDX_W   = 3;
  localparam int NUM_CH  = 5;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [NUM_CH*COUNT_W-1:0] counts;
  logic [COUNT_W+1:0]        egress_total;
  logic                      balanced, busy, done, timeout_err, stale;

  cont_reader_if #(.COUNT_W(COUNT_W), .IDX_W(IDX_W)) bus ();

  cont_reader #(
    .COUNT_W (COUNT_W),
    .IDX_W   (IDX_W),
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .counts       (counts),
    .egress_total (egress_total),
    .balanced     (balanced),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder configuration: latency 0 means the channel never answers.
  int lat  [NUM_CH];
  int vals [NUM_CH];
  bit noise_en = 1'b0;

  // Model of the current/last sequence.
  int m_start = -100;
  int m_done  = -1;
  bit m_pulse = 1'b0;
  int m_req_cyc [NUM_CH];
  int m_nreq  = 0;
  int m_counts [NUM_CH] = '{default: 0};
  int m_total = 0;
  bit m_bal   = 1'b0;
  bit m_to    = 1'b0;
  bit m_stale = 1'b0;

  int last_done = -1;
  int n_done    = 0;

  // Counter-block responder, driven mid-cycle.
  bit pend      = 1'b0;
  int pend_idx  = 0;
  int pend_left = 0;
  always @(negedge clk) begin
    bus.valid_cont   = 1'b0;
    bus.data_in_cont = COUNT_W'($urandom);
    if (bus.req) begin
      if (noise_en) bus.valid_cont = 1'b1;  // spurious strobe in the request cycle
      pend_idx  = int'(bus.idx);
      pend_left = lat[pend_idx];
      pend      = (pend_left != 0);
    end else if (pend) begin
      pend_left--;
      if (pend_left == 0) begin
        bus.valid_cont   = 1'b1;
        bus.data_in_cont = COUNT_W'(vals[pend_idx]);
        pend             = 1'b0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit exp_req;
    int exp_idx;
    exp_req = 1'b0;
    exp_idx = 0;
    for (int k = 0; k < m_nreq; k++) begin
      if (m_req_cyc[k] == cyc) begin
        exp_req = 1'b1;
        exp_idx = k;
      end
    end
    chk("busy", busy, (cyc > m_start) && (cyc < m_done));
    chk("done", done, m_pulse && (cyc == m_done));
    chk("req", bus.req, exp_req);
    if (bus.req && exp_req) chk("idx", bus.idx, exp_idx);
    if (done) begin
      last_done = cyc;
      n_done++;
    end
    if (cyc >= m_done) begin
      for (int k = 0; k < NUM_CH; k++)
        chk("counts", counts[k*COUNT_W +: COUNT_W], m_counts[k]);
      chk("egress_total", egress_total, m_total);
      chk("balanced", balanced, m_bal);
      chk("timeout_err", timeout_err, m_to);
      chk("stale", stale, m_stale);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, bus.req, 0);
    chk({tag, "_idx"}, bus.idx, 0);
    chk({tag, "_counts"}, counts, 0);
    chk({tag, "_total"}, egress_total, 0);
    chk({tag, "_balanced"}, balanced, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
    chk({tag, "_stale"}, stale, 0);
  endtask

  // One readout: builds the model from the stimulus, then drives start/idle.
  task automatic run_seq(input int idle_delay, input int drop_ch, input bit noise,
                         input bit restart, input int reset_ch, output int s_out);
    int s, i0, r, r0, done_c, nreq, d0, d1, rst_cyc, ncap;
    bit to;
    @(negedge clk);
    s  = cyc;
    i0 = (idle_delay > 1) ? s + idle_delay : s + 1;
    r  = i0 + 1;
    r0 = r;
    to = 1'b0;
    nreq = 0;
    ncap = 0;
    done_c = 0;
    d0 = -1000;
    d1 = -1000;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!to) begin
        m_req_cyc[k] = r;
        nreq = k + 1;
        if (k == drop_ch) begin
          d0 = r + 1;
          d1 = r + 4;
        end
        if (lat[k] == 0) begin
          to = 1'b1;
          done_c = r + TIMEOUT + 2;
        end else begin
          ncap = k + 1;
          r = r + 1 + lat[k];
        end
      end
    end
    if (!to) done_c = r + 2;
    for (int k = 0; k < ncap; k++) m_counts[k] = vals[k];
    if (!to) begin
      m_total = m_counts[CH_EGR0] + m_counts[CH_EGR1] + m_counts[CH_EGR2] + m_counts[CH_EGR3];
      m_bal   = (m_total == m_counts[CH_ING]);
    end
    m_to    = to;
    m_stale = (d0 <= done_c - 1) && (d1 - 1 >= r0);
    m_nreq  = nreq;
    m_pulse = 1'b1;
    m_start = s;
    m_done  = done_c;
    rst_cyc = (reset_ch >= 0) ? m_req_cyc[reset_ch] + 2 : -1;

    noise_en = noise;
    start    = 1'b1;
    bus.idle = (s >= s + idle_delay);
    while (cyc < done_c + 2) begin
      @(negedge clk);
      start    = restart && (cyc == r0 + 3);
      bus.idle = (cyc >= s + idle_delay) && !((cyc >= d0) && (cyc < d1));
      if (cyc == rst_cyc - 1) begin
        @(posedge clk);
        #2;
        reset     = 1'b1;
        m_counts  = '{default: 0};
        m_total   = 0;
        m_bal     = 1'b0;
        m_to      = 1'b0;
        m_stale   = 1'b0;
        m_pulse   = 1'b0;
        m_done    = cyc;
        m_nreq    = 0;
        for (int k = 0; k < nreq; k++)
          if (m_req_cyc[k] < cyc) m_nreq = k + 1;
        #1;
        chk_all_zero("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        break;
      end
    end
    start    = 1'b0;
    noise_en = 1'b0;
    s_out    = s;
    $display("seq start=%0d lat=%0d,%0d,%0d,%0d,%0d vals=%0d,%0d,%0d,%0d,%0d done@+%0d total=%0d bal=%0d to=%0d stale=%0d",
             s, lat[0], lat[1], lat[2], lat[3], lat[4], vals[0], vals[1], vals[2], vals[3], vals[4],
             last_done - s, egress_total, balanced, timeout_err, stale);
  endtask

  task automatic set_cfg(input int l0, l1, l2, l3, l4, input int v0, v1, v2, v3, v4);
    lat  = '{l0, l1, l2, l3, l4};
    vals = '{v0, v1, v2, v3, v4};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int nd;
    reset    = 1'b1;
    start    = 1'b0;
    bus.idle = 1'b0;
    set_cfg(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Nominal: 1-cycle answers, balanced.
    set_cfg(1, 1, 1, 1, 1, 5, 7, 9, 11, 32);
    run_seq(0, -1, 1'b0, 1'b0, -1, s);
    chk("nominal_done_cycle", last_done - s, 14);
    chk("nominal_total", egress_total, 32);
    chk("nominal_balanced", balanced, 1);
    chk("nominal_slot4", counts[4*COUNT_W +: COUNT_W], 32);

    // Imbalance with 4-cycle answers and maximal egress.
    set_cfg(4, 4, 4, 4, 4, 63, 63, 63, 63, 10);
    run_seq(0, -1, 1'b0, 1'b0, -1, s);
    chk("imbal_done_cycle", last_done - s, 29);
    chk("imbal_total", egress_total, 252);
    chk("imbal_balanced", balanced, 0);

    // Timeout on channel 2.
    set_cfg(1, 1, 0, 1, 1, 20, 21, 22, 23, 24);
    run_seq(0, -1, 1'b0, 1'b0, -1, s);
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_done_cycle", last_done - s, 23);
    chk("timeout_slot0", counts[0 +: COUNT_W], 20);
    chk("timeout_slot2", counts[2*COUNT_W +: COUNT_W], 63);
    chk("timeout_slot4", counts[4*COUNT_W +: COUNT_W], 10);
    chk("timeout_total_kept", egress_total, 252);

    // Idle gating for 20 cycles, then idle drop during channel 1.
    set_cfg(1, 1, 1, 1, 1, 1, 2, 3, 4, 10);
    run_seq(20, 1, 1'b0, 1'b0, -1, s);
    chk("stale_flag", stale, 1);
    chk("stale_done_cycle", last_done - s, 33);
    chk("stale_timeout_cleared", timeout_err, 0);

    // Protocol noise: strobe in request cycles plus a start while busy.
    set_cfg(2, 2, 2, 2, 2, 9, 8, 7, 6, 30);
    nd = n_done;
    run_seq(0, -1, 1'b1, 1'b1, -1, s);
    chk("noise_done_once", n_done - nd, 1);
    chk("noise_slot0", counts[0 +: COUNT_W], 9);
    chk("noise_total", egress_total, 30);

    // Reset while waiting on channel 3, then a clean run.
    set_cfg(1, 1, 1, 8, 1, 40, 41, 42, 43, 44);
    run_seq(0, -1, 1'b0, 1'b0, 3, s);
    set_cfg(1, 1, 1, 1, 1, 3, 3, 3, 3, 12);
    run_seq(0, -1, 1'b0, 1'b0, -1, s);
    chk("post_reset_total", egress_total, 12);
    chk("post_reset_balanced", balanced, 1);

    // Randomized sequences.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        lat[k]  = int'($urandom_range(1, TIMEOUT));
        vals[k] = int'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 4) == 0) lat[$urandom_range(0, NUM_CH - 1)] = 0;
      if ($urandom_range(0, 3) == 0) vals[CH_ING] = vals[0] + vals[1] + vals[2] + vals[3] <= 63 ?
                                                    vals[0] + vals[1] + vals[2] + vals[3] : vals[CH_ING];
      run_seq(int'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, s);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cont_reader.md
# cont_reader

Readout sequencer downstream of the transaction layer's packet counter. After a software `start`, it waits for the layer to report `idle`, then issues one `req`/`idx` query for each of the five counter channels (egress FIFOs 0–3, then ingress FIFO) and captures each `data_out_cont` return. It publishes all five counts, the egress total, and a balance check (egress total equal to ingress count), with timeout and stale-snapshot flags.

## Interface
Parameters:
- `COUNT_W`, 6: width of one counter value (`data_out_cont`).
- `IDX_W`, 3: width of the `idx` channel selector.
- `NUM_CH`, 5: channels read per sequence, indices 0..NUM_CH-1.
- `TIMEOUT`, 15: maximum cycles to wait for `valid_cont` after each `req`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a readout; honoured only in `S_IDLE`.
- `idle`  in  1  transaction layer idle indication from its FSM.
- `req`  out  1  counter read request, one-cycle pulse per channel.
- `idx`  out  IDX_W  channel being queried; held from the `req` cycle until capture.
- `data_in_cont`  in  COUNT_W  counter value returned by the layer.
- `valid_cont`  in  1  qualifies `data_in_cont`.
- `counts`  out  NUM_CH*COUNT_W  captured values; channel k at bits [k*COUNT_W +: COUNT_W].
- `egress_total`  out  COUNT_W+2  sum of channels 0..3.
- `balanced`  out  1  `egress_total == counts[4]` (ingress), zero-extended compare.
- `busy`  out  1  high in every state except `S_IDLE`.
- `done`  out  1  one-cycle pulse at sequence end, on success or error.
- `timeout_err`  out  1  sticky until next `start`: a channel did not answer in time.
- `stale`  out  1  sticky until next `start`: `idle` dropped during the sequence.

## Operation
- All outputs are registered. Every output resets to 0: `req`, `idx`, `counts`, `egress_total`, `balanced`, `busy`, `done`, `timeout_err`, `stale`.
- States:
  - `S_IDLE` → `S_WAIT_IDLE` on `start`. Entry clears `timeout_err`, `stale`, and the channel pointer k. `counts` keeps its last values until overwritten.
  - `S_WAIT_IDLE` → `S_REQ` when `idle`=1. There is no timeout here; the block waits indefinitely.
  - `S_REQ` drives `req`=1 and `idx`=k for exactly one cycle, clears the wait timer, then goes to `S_WAIT`.
  - `S_WAIT`:
    - On `valid_cont`=1, capture `data_in_cont` into slot k.
    - If k=NUM_CH-1, go to `S_SUM`; otherwise k++ and go to `S_REQ`.
    - If the timer reaches TIMEOUT with no valid, set `timeout_err` and go to `S_DONE`. Slots not yet read keep their old values.
  - `S_SUM` registers `egress_total` and `balanced`, then goes to `S_DONE`.
  - `S_DONE` pulses `done` for one cycle, then returns to `S_IDLE`.
- `start` while `busy` is ignored.
- Once the sequence has passed `S_WAIT_IDLE`, `idle`=0 sets `stale` but does not abort.
- `valid_cont` during `S_REQ`, `S_IDLE`, or `S_WAIT_IDLE` is ignored. Only the first valid in `S_WAIT` is captured.
- Arithmetic: `egress_total` is a COUNT_W+2-bit unsigned sum and cannot overflow (4×63=252). `balanced` is unmodified when the sequence ends by timeout.
- Asynchronous `reset` mid-sequence returns the block to `S_IDLE` with all outputs 0. No partial result survives.

## Timing
- `start` at cycle 0 with `idle` already 1: `req` in cycle 2. The `S_IDLE`→`S_WAIT_IDLE` and `S_WAIT_IDLE`→`S_REQ` transitions each take one edge.
- Per channel: one `S_REQ` cycle plus W wait cycles, where W is the cycles until `valid_cont` (1 ≤ W ≤ TIMEOUT).
- Capture happens on the edge where `valid_cont`=1. The next `req` follows exactly one cycle later.
- Timeout triggers when `valid_cont` has stayed low for TIMEOUT consecutive `S_WAIT` cycles.
- `done` occurs 2 cycles after the final capture (`S_SUM`, then `S_DONE`). `egress_total` and `balanced` are valid in the `done` cycle.
- Minimum sequence, with `idle`=1 and 1-cycle answers: `done` at cycle 2 + 5×2 + 2 = 14.

## Structure
- Shared package `trans_pkg`:
  - state encoding for `S_IDLE`, `S_WAIT_IDLE`, `S_REQ`, `S_WAIT`, `S_SUM`, `S_DONE`;
  - channel index constants `CH_EGR0`..`CH_EGR3` and `CH_ING`=4;
  - `COUNT_W` and `IDX_W` defaults.
- One natural sub-module, `wait_timer`: a loadable down-counter with a `clear` input and an `expired` output, parameterised on TIMEOUT.
- The FSM, the capture registers, and the sum logic stay in `cont_reader`.

## Test plan
- Nominal: `idle`=1, responder returns 5,7,9,11,32 one cycle after each `req` → `idx` sequence 0,1,2,3,4; `egress_total`=32; `balanced`=1; `done` at cycle 14; `timeout_err`=0.
- Imbalance with delayed answers: values 63,63,63,63,10, each answered 4 cycles after `req` → `egress_total`=252, `balanced`=0, no overflow.
- Timeout: responder never answers `idx`=2 → `done` pulses and `timeout_err`=1 after TIMEOUT wait cycles; slots 0–1 updated, slots 2–4 unchanged; no `req` with `idx`=3.
- Idle gating and stale: `start` with `idle`=0 for 20 cycles → no `req` until `idle` rises; then drop `idle` during channel 1 → sequence completes with `stale`=1.
- Protocol noise: `valid_cont` pulsed during the `S_REQ` cycle and a second `start` while `busy` → spurious data not captured, no restart, `done` pulses once.
- Reset mid-sequence: assert `reset` during `S_WAIT` for channel 3 → all outputs 0 immediately; a fresh `start` then completes normally.
